uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, number of data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 8, clk cycles per serial bit.
REQ-003 SHALL have clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have reset_n  input  1  asynchronous reset, active low.
REQ-005 SHALL have data_in  input  DATA_SIZE  byte to transmit, sampled when tx_start_n is low.
REQ-006 SHALL have tx_start_n  input  1  active-low transmit request, one byte per low cycle.
REQ-007 SHALL have serial_data_out  output  1  registered serial line, idle high.
REQ-008 SHALL have tx_busy  output  1  high while any frame bit is being driven.
REQ-009 SHALL have tx_ready  output  1  high when the holding register is empty.
REQ-010 SHALL have tx_done  output  1  one-cycle pulse in the last cycle of a stop bit.
REQ-011 SHALL have overflow_error  output  1  one-cycle pulse when a request is dropped.

Function
REQ-012 Frame SHALL be: start 0, DATA_SIZE data bits LSB first, parity bit (with UART_TX_PARITY_EN), stop 1.
REQ-013 Parity bit SHALL equal XOR of all data bits (even parity over data plus parity).
REQ-014 Each bit SHALL last exactly CLKS_PER_BIT cycles, counted by a sample counter 0..CLKS_PER_BIT-1.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP (one-hot encoded).
REQ-016 IDLE: line 1; tx_start_n low -> load shift register from data_in, go START, line 0 on the next cycle.
REQ-017 START -> DATA after CLKS_PER_BIT cycles; DATA shifts right one bit per bit period, bit counter 0..DATA_SIZE-1.
REQ-018 DATA -> PARITY after bit DATA_SIZE-1; PARITY -> STOP after one bit period.
REQ-019 STOP end: holding register full -> load it, go START with no idle cycle; else go IDLE.
REQ-020 tx_start_n low while tx_busy and holding empty SHALL capture data_in into holding register; tx_ready drops next cycle.
REQ-021 tx_start_n low while holding full SHALL drop data_in and pulse overflow_error next cycle; frame in flight unaffected.
REQ-022 Request in the same cycle the holding register is consumed SHALL be captured, not flagged as overflow.
REQ-023 tx_busy SHALL be high in START, DATA, PARITY, STOP; low in IDLE.
REQ-024 Counters SHALL clear on every state transition; bit counter width $clog2(DATA_SIZE)+1.

Reset
REQ-025 reset_n low SHALL immediately force state IDLE, serial_data_out 1, tx_busy 0, tx_ready 1, tx_done 0, overflow_error 0.
REQ-026 reset_n low SHALL clear shift register, holding register, both counters; a frame in flight is abandoned.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined SHALL include the PARITY state and parity bit; frame is DATA_SIZE+3 bits.
REQ-028 Macro UART_TX_PARITY_EN undefined SHALL remove PARITY; DATA goes directly to STOP; frame is DATA_SIZE+2 bits.

Verification
REQ-029 Parity on, data_in 0xA5 pulse -> line 0,1,0,1,0,0,1,0,1,0(parity),1 each 8 cycles; tx_done at cycle 88.
REQ-030 Parity on, 0x01 -> parity bit 1; parity off, 0x01 -> 80-cycle frame, no parity bit.
REQ-031 0x11 then 0x22 requested during frame -> second start bit directly follows first stop bit, tx_ready 1 after load.
REQ-032 Three requests 0x11, 0x22, 0x33 back-to-back while busy -> 0x33 dropped, overflow_error pulses once.
REQ-033 reset_n low at cycle 30 of 0xA5 frame -> line 1 same cycle, tx_busy 0; new 0x5A afterwards sent correctly.

Source files
------------

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: byte request and serial status bundle of the UART transmitter
// Parameter: DATA_SIZE - data bits per frame
// Signals:
//   data_in         byte to transmit, sampled while tx_start_n is low
//   tx_start_n      active-low transmit request, one byte per low cycle
//   serial_data_out registered serial line, idle high
//   tx_busy         high while any frame bit is driven
//   tx_ready        high while the holding register is empty
//   tx_done         one-cycle pulse in the last cycle of a stop bit
//   overflow_error  one-cycle pulse when a request is dropped
// Modports: master (requester side), slave (transmitter side)
interface uart_transmitter_if #(parameter int DATA_SIZE = 8);
  logic [DATA_SIZE-1:0] data_in;
  logic tx_start_n;
  logic serial_data_out;
  logic tx_busy;
  logic tx_ready;
  logic tx_done;
  logic overflow_error;
  modport master(output data_in, tx_start_n,
                 input serial_data_out, tx_busy, tx_ready, tx_done, overflow_error);
  modport slave(input data_in, tx_start_n,
                output serial_data_out, tx_busy, tx_ready, tx_done, overflow_error);
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: UART serialiser with one-entry holding register and overflow flag
// Parameters: DATA_SIZE (data bits per frame), CLKS_PER_BIT (clk cycles per serial bit)
// Ports:
//   clk     rising-edge clock
//   reset_n asynchronous active-low reset
//   bus     uart_transmitter_if.slave (data_in, tx_start_n in; serial_data_out,
//           tx_busy, tx_ready, tx_done, overflow_error out)
// Option: define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_transmitter #(
  parameter int DATA_SIZE    = 8,
  parameter int CLKS_PER_BIT = 8
) (
  input logic               clk,
  input logic               reset_n,
  uart_transmitter_if.slave bus
);
  localparam int SW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_SIZE) + 1;
  localparam logic [SW-1:0] LAST_S = SW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_B = BW'(DATA_SIZE - 1);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
`ifdef UART_TX_PARITY_EN
    PARITY = 5'b01000,
`endif
    STOP   = 5'b10000
  } state_t;

  state_t               r_state;
  logic [DATA_SIZE-1:0] r_shift;
  logic [DATA_SIZE-1:0] r_hold;
  logic [SW-1:0]        r_sample;
  logic [BW-1:0]        r_bit;
  logic                 r_line;
  logic                 r_busy;
  logic                 r_ready;
  logic                 r_done;
  logic                 r_ovf;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic                 w_req;
  logic                 w_bit_end;
  logic                 w_stop_end;
  logic                 w_load;
  logic                 w_capture;
  logic                 w_drop;
  logic [DATA_SIZE-1:0] w_load_val;

  assign w_req      = !bus.tx_start_n;
  assign w_bit_end  = r_sample == LAST_S;
  assign w_stop_end = r_state == STOP && w_bit_end;
  // Next frame starts from IDLE on a request, or straight out of a stop bit when
  // either the holding register is full or a request arrives in that very cycle.
  assign w_load     = (r_state == IDLE && w_req) || (w_stop_end && (!r_ready || w_req));
  // An empty holding register means the byte comes directly from data_in.
  assign w_load_val = r_ready ? bus.data_in : r_hold;
  // A request at the end of a stop bit with holding empty bypasses the holding
  // register; with holding full it refills the register being consumed.
  assign w_capture  = w_req && r_state != IDLE && (r_ready ? !w_stop_end : w_stop_end);
  assign w_drop     = w_req && r_state != IDLE && !r_ready && !w_stop_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_hold   <= '0;
      r_sample <= '0;
      r_bit    <= '0;
      r_line   <= 1'b1;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_done   <= 1'b0;
      r_ovf    <= w_drop;
      r_sample <= (r_state == IDLE || w_bit_end) ? '0 : r_sample + 1'b1;
      if (w_capture) begin
        r_hold  <= bus.data_in;
        r_ready <= 1'b0;
      end else if (w_stop_end && !r_ready) begin
        r_ready <= 1'b1;
      end
      if (w_load) begin
        r_shift  <= w_load_val;
`ifdef UART_TX_PARITY_EN
        r_parity <= ^w_load_val;
`endif
      end
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state <= START;
            r_line  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            r_bit   <= '0;
            r_line  <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_bit == LAST_B) begin
              r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
              r_line  <= r_parity;
`else
              r_state <= STOP;
              r_line  <= 1'b1;
              r_done  <= CLKS_PER_BIT == 1;
`endif
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_line  <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_state <= STOP;
            r_line  <= 1'b1;
            r_done  <= CLKS_PER_BIT == 1;
          end
        end
`endif
        STOP: begin
          // tx_done is registered, so it is raised on entry to the final stop cycle.
          r_done <= !w_bit_end && r_sample == LAST_S - 1'b1;
          if (w_bit_end) begin
            if (w_load) begin
              r_state <= START;
              r_line  <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.serial_data_out = r_line;
  assign bus.tx_busy         = r_busy;
  assign bus.tx_ready        = r_ready;
  assign bus.tx_done         = r_done;
  assign bus.overflow_error  = r_ovf;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed self-checking bench for uart_transmitter
module tb_uart_transmitter;
  localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  uart_transmitter_if #(.DATA_SIZE(8)) bus();

  uart_transmitter #(.DATA_SIZE(8), .CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line levels, index 0 = start bit, then data LSB first, parity, stop.
  function automatic logic [NB-1:0] frame_bits(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [7:0] d);
    bus.data_in    = d;
    bus.tx_start_n = 1'b0;
    tick;
    bus.tx_start_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n        = 1'b0;
    bus.tx_start_n = 1'b1;
    bus.data_in    = '0;
    repeat (3) tick;
    checks++;
    if (bus.serial_data_out !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_ready !== 1'b1 ||
        bus.tx_done !== 1'b0 || bus.overflow_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: line=%b busy=%b ready=%b done=%b ovf=%b, expected 1 0 1 0 0",
               bus.serial_data_out, bus.tx_busy, bus.tx_ready, bus.tx_done, bus.overflow_error);
    end
    reset_n = 1'b1;
    repeat (2) tick;
    checks++;
    if (bus.serial_data_out !== 1'b1 || bus.tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: line=%b busy=%b, expected 1 0", bus.serial_data_out, bus.tx_busy);
    end
  endtask

  task automatic test_frame(input logic [7:0] d);
    logic [NB-1:0] fb;
    fb = frame_bits(d);
    req(d);
    for (int cy = 0; cy < FL; cy++) begin
      checks++;
      if (bus.serial_data_out !== fb[cy/CPB] || bus.tx_done !== (cy == FL-1) ||
          bus.tx_busy !== 1'b1 || bus.tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL frame_%h cycle %0d: line=%b done=%b busy=%b ready=%b, expected line=%b done=%b busy=1 ready=1",
                 d, cy, bus.serial_data_out, bus.tx_done, bus.tx_busy, bus.tx_ready, fb[cy/CPB], cy == FL-1);
      end
      tick;
    end
    checks++;
    if (bus.serial_data_out !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_%h_idle: line=%b busy=%b done=%b, expected 1 0 0",
               d, bus.serial_data_out, bus.tx_busy, bus.tx_done);
    end
  endtask

  task automatic test_back_to_back;
    logic [NB-1:0] fb [2];
    logic          exp_ready;
    fb[0] = frame_bits(8'h11);
    fb[1] = frame_bits(8'h22);
    req(8'h11);
    for (int cy = 0; cy < 2*FL; cy++) begin
      exp_ready = cy <= 10 || cy >= FL;
      checks++;
      if (bus.serial_data_out !== fb[cy/FL][(cy%FL)/CPB] || bus.tx_done !== ((cy%FL) == FL-1) ||
          bus.tx_ready !== exp_ready || bus.tx_busy !== 1'b1 || bus.overflow_error !== 1'b0) begin
        errors++;
        $display("FAIL b2b cycle %0d: line=%b done=%b ready=%b busy=%b ovf=%b, expected line=%b done=%b ready=%b busy=1 ovf=0",
                 cy, bus.serial_data_out, bus.tx_done, bus.tx_ready, bus.tx_busy, bus.overflow_error,
                 fb[cy/FL][(cy%FL)/CPB], (cy%FL) == FL-1, exp_ready);
      end
      bus.data_in    = 8'h22;
      bus.tx_start_n = cy != 10;
      tick;
    end
    checks++;
    if (bus.serial_data_out !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: line=%b busy=%b ready=%b, expected 1 0 1",
               bus.serial_data_out, bus.tx_busy, bus.tx_ready);
    end
  endtask

  task automatic test_overflow;
    logic [NB-1:0] fb [2];
    logic          exp_ready;
    int            pulses;
    fb[0]  = frame_bits(8'h11);
    fb[1]  = frame_bits(8'h22);
    pulses = 0;
    req(8'h11);
    for (int cy = 0; cy < 2*FL; cy++) begin
      exp_ready = cy == 0 || cy >= FL;
      pulses += int'(bus.overflow_error === 1'b1);
      checks++;
      if (bus.serial_data_out !== fb[cy/FL][(cy%FL)/CPB] || bus.overflow_error !== (cy == 2) ||
          bus.tx_ready !== exp_ready || bus.tx_done !== ((cy%FL) == FL-1)) begin
        errors++;
        $display("FAIL overflow cycle %0d: line=%b ovf=%b ready=%b done=%b, expected line=%b ovf=%b ready=%b done=%b",
                 cy, bus.serial_data_out, bus.overflow_error, bus.tx_ready, bus.tx_done,
                 fb[cy/FL][(cy%FL)/CPB], cy == 2, exp_ready, (cy%FL) == FL-1);
      end
      bus.data_in    = cy == 0 ? 8'h22 : 8'h33;
      bus.tx_start_n = !(cy == 0 || cy == 1);
      tick;
    end
    checks++;
    if (pulses !== 1 || bus.tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow_count: pulses=%0d busy=%b, expected pulses=1 busy=0", pulses, bus.tx_busy);
    end
  endtask

  task automatic test_consume;
    logic [NB-1:0] fb [4];
    logic          exp_ready;
    fb[0] = frame_bits(8'h11);
    fb[1] = frame_bits(8'h22);
    fb[2] = frame_bits(8'h44);
    fb[3] = frame_bits(8'h77);
    req(8'h11);
    for (int cy = 0; cy < 4*FL; cy++) begin
      exp_ready = cy == 0 || cy >= 2*FL;
      checks++;
      if (bus.serial_data_out !== fb[cy/FL][(cy%FL)/CPB] || bus.overflow_error !== 1'b0 ||
          bus.tx_ready !== exp_ready || bus.tx_busy !== 1'b1 || bus.tx_done !== ((cy%FL) == FL-1)) begin
        errors++;
        $display("FAIL consume cycle %0d: line=%b ovf=%b ready=%b busy=%b done=%b, expected line=%b ovf=0 ready=%b busy=1 done=%b",
                 cy, bus.serial_data_out, bus.overflow_error, bus.tx_ready, bus.tx_busy, bus.tx_done,
                 fb[cy/FL][(cy%FL)/CPB], exp_ready, (cy%FL) == FL-1);
      end
      bus.data_in    = cy == 0 ? 8'h22 : cy == FL-1 ? 8'h44 : 8'h77;
      bus.tx_start_n = !(cy == 0 || cy == FL-1 || cy == 3*FL-1);
      tick;
    end
    checks++;
    if (bus.serial_data_out !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL consume_idle: line=%b busy=%b ready=%b, expected 1 0 1",
               bus.serial_data_out, bus.tx_busy, bus.tx_ready);
    end
  endtask

  task automatic test_reset_midframe;
    req(8'hA5);
    for (int cy = 0; cy < 30; cy++) begin
      bus.data_in    = 8'h3C;
      bus.tx_start_n = cy != 5;
      tick;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.serial_data_out !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_ready !== 1'b1 ||
        bus.tx_done !== 1'b0 || bus.overflow_error !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: line=%b busy=%b ready=%b done=%b ovf=%b, expected 1 0 1 0 0",
               bus.serial_data_out, bus.tx_busy, bus.tx_ready, bus.tx_done, bus.overflow_error);
    end
    tick;
    reset_n = 1'b1;
    for (int cy = 0; cy < 2*CPB; cy++) begin
      checks++;
      if (bus.serial_data_out !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_idle cycle %0d: line=%b busy=%b ready=%b, expected 1 0 1",
                 cy, bus.serial_data_out, bus.tx_busy, bus.tx_ready);
      end
      tick;
    end
    test_frame(8'h5A);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_frame(8'hA5);
    test_frame(8'h01);
    test_back_to_back;
    test_overflow;
    test_consume;
    test_reset_midframe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
